// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_pkg
// Brief    : Shared types and default geometry for the UART RX frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_frame_pkg;

  localparam int c_data_w_def     = 8;
  localparam int c_oversample_def = 16;
  localparam int c_samp_w_def     = $clog2(c_oversample_def);
  localparam int c_bit_w_def      = $clog2(c_data_w_def + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Counter bundle sized for the default frame geometry
  typedef struct packed {
    logic [c_samp_w_def-1:0] samp_cnt;
    logic [c_bit_w_def-1:0]  bit_cnt;
    logic                    samp_ovf;
  } rx_cntr_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_cntr_rx_sample_ovf.sv
`default_nettype none
// ============================================================================
// Module   : cntr_rx_sample_ovf
// Brief    : Tick-enabled oversample counter, wraps at OVERSAMPLE-1 with ovf.
// Revision : 1.0 - initial release
// ============================================================================
module cntr_rx_sample_ovf #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enb,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (enb) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign ovf = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : UART frame receiver: sync, start detect, mid-bit sampling, stop
//            check. Optional even parity when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_W      = c_data_w_def,
  parameter int OVERSAMPLE  = c_oversample_def,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb_tick,
  input  logic              clear,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int c_samp_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = $clog2(DATA_W + 1);
  localparam logic [c_samp_w-1:0] c_mid      = c_samp_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [c_samp_w-1:0]    w_samp_cnt;
  logic                   w_samp_ovf;
  logic [c_bit_w-1:0]     r_bit_cnt;
  rx_cntr_t               w_cntr;
  logic [DATA_W-1:0]      r_shreg;
  logic [DATA_W-1:0]      r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_armed;
  logic                   w_tick_ovf;
  logic                   w_cnt_clr;
  logic                   w_shift;
  logic                   w_load;
  logic                   w_ferr;
  logic                   w_arm;
  logic                   w_disarm;
`ifdef UART_RX_PARITY_EN
  logic                   w_par_cap;
  logic                   r_par_bad;
  logic                   r_perr;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  cntr_rx_sample_ovf #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (c_samp_w)
  ) u_samp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_cnt_clr),
    .enb (enb_tick),
    .cnt (w_samp_cnt),
    .ovf (w_samp_ovf)
  );

  assign w_cntr     = '{samp_cnt: w_samp_cnt, bit_cnt: r_bit_cnt, samp_ovf: w_samp_ovf};
  assign w_tick_ovf = enb_tick & w_cntr.samp_ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    w_arm       = 1'b0;
    w_disarm    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_cap   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (enb_tick) begin
          if (r_armed && !w_rx_s) begin
            w_state_nxt = START;
          end else if (!r_armed && w_rx_s) begin
            w_arm = 1'b1;
          end
        end
      end
      START: begin
        // Decision on the tick that brings the count to the mid-bit point
        if (enb_tick && ((w_cntr.samp_cnt + c_samp_w'(1)) == c_mid)) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick_ovf) begin
          w_shift = 1'b1;
          if (w_cntr.bit_cnt == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick_ovf) begin
          w_par_cap   = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tick_ovf) begin
          w_state_nxt = IDLE;
          if (w_rx_s) begin
            w_load = 1'b1;
          end else begin
            // Break or garbage: hold off until the line returns high
            w_ferr   = 1'b1;
            w_disarm = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear) begin
      w_state_nxt = IDLE;
      w_cnt_clr   = 1'b1;
      w_shift     = 1'b0;
      w_load      = 1'b0;
      w_ferr      = 1'b0;
      w_arm       = 1'b0;
      w_disarm    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_cap   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      r_valid <= w_load;
      r_ferr  <= w_ferr;
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_shift) begin
        r_shreg <= {w_rx_s, r_shreg[DATA_W-1:1]};
      end
      if (w_load) begin
        r_data <= r_shreg;
      end
      if (w_arm) begin
        r_armed <= 1'b1;
      end else if (w_disarm) begin
        r_armed <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_perr <= w_load & r_par_bad;
      if (w_par_cap) begin
        r_par_bad <= ^{r_shreg, w_rx_s};
      end
    end
  end

  assign parity_err = r_perr;
`endif

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
